// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encoding,
// the control bundle driven to the PC and pipeline buffer registers, and
// the canned control patterns for each hazard resolution.
package Pipe_Buf_Reg_PKG;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } pipe_ctrl_state_e;

    // Load enables and bubble-inserting flushes for PC and IF/ID..MEM/WB
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
        logic pc_sel;
        logic dmem_valid;
    } pipe_ctrl_t;

    // Held in reset: nothing loads, every buffer presents a bubble
    localparam pipe_ctrl_t CTRL_RESET = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0,
        if_id_flush: 1'b1, id_ex_flush: 1'b1, mem_wb_flush: 1'b1,
        pc_sel: 1'b0, dmem_valid: 1'b0};

    // First cycle after reset: load a bubble into every buffer register
    localparam pipe_ctrl_t CTRL_INIT = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_flush: 1'b1, id_ex_flush: 1'b1, mem_wb_flush: 1'b1,
        pc_sel: 1'b0, dmem_valid: 1'b0};

    localparam pipe_ctrl_t CTRL_ADVANCE = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_flush: 1'b0,
        pc_sel: 1'b0, dmem_valid: 1'b0};

    // Wrong-path instructions in IF/ID and ID/EX are squashed
    localparam pipe_ctrl_t CTRL_REDIRECT = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_flush: 1'b1, id_ex_flush: 1'b1, mem_wb_flush: 1'b0,
        pc_sel: 1'b1, dmem_valid: 1'b0};

    // Freeze PC and IF/ID, push one bubble into ID/EX
    localparam pipe_ctrl_t CTRL_LOAD_USE = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b1, mem_wb_flush: 1'b0,
        pc_sel: 1'b0, dmem_valid: 1'b0};

    // Freeze everything up to EX/MEM; MEM/WB keeps draining with bubbles
    localparam pipe_ctrl_t CTRL_MEM_STALL = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_flush: 1'b1,
        pc_sel: 1'b0, dmem_valid: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register that the
// instruction in ID actually reads. x0 never creates a dependency.
module hazard_detect
    import Pipe_Buf_Reg_PKG::*;
(
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    output logic             load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // Source operand match against the pending load destination
    always_comb begin
        rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
        load_use = ex_memread && (ex_rd != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves memory stalls,
// EX redirects and load-use hazards, keeps saturating stall/flush counters
// and a sticky data-memory timeout flag.
module pipe_hazard_ctrl
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int PC_W        = 9,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_redirect,
    input  logic [PC_W-1:0]  ex_target,
    input  logic             mem_req,
    input  logic             dmem_ack,
    input  logic             cnt_clr,
    output logic             dmem_valid,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             pc_sel,
    output logic [PC_W-1:0]  next_pc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err
);

    localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    pipe_ctrl_state_e  state_q, state_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mem_err_q, mem_err_d;
    pipe_ctrl_t        ctrl;
    logic              load_use;
    logic              stall_inc;
    logic              flush_inc;

    hazard_detect u_hazard_detect (
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .load_use   (load_use)
    );

    // Priority resolution of hazards and next-state / timeout bookkeeping
    always_comb begin
        ctrl      = CTRL_RESET;
        state_d   = state_q;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        wait_d    = wait_q;
        mem_err_d = mem_err_q;
        unique case (state_q)
            INIT: begin
                ctrl    = CTRL_INIT;
                wait_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                wait_d = '0;
                if (mem_req && !dmem_ack) begin
                    // A redirect in EX stays parked in ID/EX until release
                    ctrl      = CTRL_MEM_STALL;
                    stall_inc = 1'b1;
                    state_d   = MEM_WAIT;
                end else if (ex_redirect) begin
                    // Beats load-use: the ID instruction is wrong-path anyway
                    ctrl      = CTRL_REDIRECT;
                    flush_inc = 1'b1;
                end else if (load_use) begin
                    ctrl      = CTRL_LOAD_USE;
                    stall_inc = 1'b1;
                end else begin
                    ctrl = CTRL_ADVANCE;
                end
                ctrl.dmem_valid = mem_req;
            end
            MEM_WAIT: begin
                // The ack cycle itself is still a stall; advance next cycle
                ctrl      = CTRL_MEM_STALL;
                stall_inc = 1'b1;
                wait_d    = (wait_q < WAIT_MAX) ? wait_q + 1'b1 : wait_q;
                if (wait_d == WAIT_MAX) begin
                    mem_err_d = 1'b1;
                end
                if (dmem_ack) begin
                    state_d = RUN;
                end
            end
            default: begin
                ctrl    = CTRL_INIT;
                state_d = INIT;
            end
        endcase
        // Outputs must show reset values while rst_n is low, not INIT ones
        if (!rst_n) begin
            ctrl = CTRL_RESET;
        end
    end

    // Saturating performance counters; clear wins over increment
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    // State, counters and sticky timeout registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_q      <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_q      <= wait_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign if_id_en     = ctrl.if_id_en;
    assign id_ex_en     = ctrl.id_ex_en;
    assign ex_mem_en    = ctrl.ex_mem_en;
    assign mem_wb_en    = ctrl.mem_wb_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign pc_sel       = ctrl.pc_sel;
    assign dmem_valid   = ctrl.dmem_valid;
    assign next_pc      = rst_n ? ex_target : '0;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;
    assign mem_err      = mem_err_q;

endmodule
